lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit that sits directly downstream of the ALU.
- Takes the ALU effective address (rs1 + imm) for OP_LW/OP_SW, plus funct3 and the store data (rs2).
- Runs a single-outstanding request/acknowledge transaction on the data-memory bus.
- Returns an aligned, sign/zero-extended load result to writeback; flags misaligned accesses and bus timeouts as exceptions.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles mem_req may stay high without mem_ack before bus_error; 0 disables the timeout.
- ADDR_W, 32: width of mem_addr.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- is_store  in  1  1 = store (OP_SW), 0 = load (OP_LW)
- funct3  in  3  access type: MEM_B=000, MEM_H=001, MEM_W=010, LBU=100, LHU=101
- addr  in  32  effective address from ALU rd
- wdata  in  32  store data (rs2)
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse; transaction finished
- rdata  out  32  load result, valid while done=1, held afterwards
- misaligned  out  1  one-cycle pulse with done; address-alignment fault
- bus_error  out  1  one-cycle pulse with done; timeout or illegal funct3
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address, {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data replicated into lanes
- mem_ack  in  1  memory completes the beat; mem_rdata valid this cycle
- mem_rdata  in  32  read word

Behaviour:
- Reset: state=IDLE; every output 0; timeout counter 0. Reset mid-transaction drops mem_req at the next edge with no done pulse.
- States: IDLE, REQ, RESP.
- IDLE, start=1: all inputs are latched.
  - funct3 illegal (011, 110, 111, or 1xx with is_store=1): go to RESP with bus_error.
  - Misaligned (H/HU with addr[0]≠0; W with addr[1:0]≠0): go to RESP with misaligned. No bus access in either fault case.
  - Otherwise: go to REQ.
- start outside IDLE is ignored.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata stable until the cycle mem_ack is seen.
  - Counter increments each cycle without ack.
  - On mem_ack: capture and extend mem_rdata, then go to RESP.
  - Counter reaching TIMEOUT_CYCLES: go to RESP with bus_error, rdata=0.
  - mem_req deasserts on the edge after ack.
- RESP: done=1 for exactly one cycle with the fault flags; return to IDLE. start is accepted again in the following cycle.
- Latency: start at cycle 0 → mem_req at cycle 1; ack at cycle k → done at cycle k+1. Zero-wait memory (ack at cycle 1) gives done at cycle 2. Fault paths give done at cycle 1.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0]
  - H/HU: 4'b0011 << addr[1:0]
  - W: 4'b1111
- Store data: byte replicated ×4; half replicated ×2; word as-is.
- Loads: select lane by addr[1:0], then sign-extend (B, H) or zero-extend (LBU, LHU). W passes through unchanged.
- Stores: rdata=0.
- mem_ack outside REQ is ignored.

Decomposition:
- Shared package:
  - FUNCT3_MEM_B/H/W, FUNCT3_LBU/LHU, OP_LW/OP_SW
  - lsu_state_t enum
  - lsu_size_t
- Sub-module lsu_align (combinational): lane select plus extension for loads; byte-enable generation plus data replication for stores. Reused by any future cache.

Test Plan:
- LW addr=0x1000_0008, mem_rdata=0xDEADBEEF, ack at cycle 1 → mem_be=1111, mem_addr=0x1000_0008; done at cycle 2 with rdata=0xDEADBEEF.
- LB addr=0x..0003, mem_rdata=0x80_11_22_33 → mem_be=1000, rdata=0xFFFF_FF80. LBU at the same address → rdata=0x0000_0080.
- SH addr=0x..0002, wdata=0x0000_ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD.
- LW addr=0x..0006 → no mem_req, done + misaligned at cycle 1. SB with funct3=100 → done + bus_error at cycle 1.
- TIMEOUT_CYCLES=4, mem_ack never asserted → mem_req high 4 cycles, then done + bus_error, rdata=0.
- Reset asserted while in REQ → next cycle mem_req=0, busy=0, no done. start held high while busy → exactly one transaction.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared types and encodings for the load/store unit: funct3 access codes,
// controller states and access sizes.
package lsu_ctrl_pkg;

    localparam logic [2:0] FUNCT3_MEM_B = 3'b000;
    localparam logic [2:0] FUNCT3_MEM_H = 3'b001;
    localparam logic [2:0] FUNCT3_MEM_W = 3'b010;
    localparam logic [2:0] FUNCT3_LBU   = 3'b100;
    localparam logic [2:0] FUNCT3_LHU   = 3'b101;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_t;

    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // Unsigned variants exist only for loads; 011/111/110 are never legal.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        return (f3[1:0] == 2'b11) || (f3 == 3'b110) || (is_store && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store-data replication on the way
// out, lane select plus sign/zero extension on the way back.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    lsu_size_t   w_size;
    logic        w_sext;
    logic [31:0] w_shifted;

    always_comb begin
        w_size       = f3_size(i_funct3);
        w_sext       = ~i_funct3[2];
        w_shifted    = i_rdata >> {i_lane, 3'b000};
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_rdata      = w_shifted;
        o_misaligned = 1'b0;
        case (w_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_sext & w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                o_be         = 4'b0011 << i_lane;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
                o_misaligned = i_lane[0];
            end
            default: begin
                o_misaligned = |i_lane;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: single-outstanding req/ack transaction on the data bus,
// with misalignment, illegal-funct3 and timeout faults reported alongside done.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic              bus_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic [1:0]        r_lane;
    logic              r_is_store;
    logic              r_busy, r_done, r_mis, r_berr, r_req, r_we;
    logic [31:0]       r_rdata, r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;

    logic [2:0]        w_funct3;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_rdata;
    logic              w_mis;

    // One align instance: live inputs while issuing, latched ones while waiting for ack.
    assign w_funct3 = (r_state == ST_IDLE) ? funct3     : r_funct3;
    assign w_lane   = (r_state == ST_IDLE) ? addr[1:0]  : r_lane;

    lsu_align u_align (
        .i_funct3     (w_funct3),
        .i_lane       (w_lane),
        .i_wdata      (wdata),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_rdata),
        .o_misaligned (w_mis)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_funct3   <= '0;
            r_lane     <= '0;
            r_is_store <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mis      <= 1'b0;
            r_berr     <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_rdata    <= '0;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_be       <= '0;
        end else begin
            r_done <= 1'b0;
            r_mis  <= 1'b0;
            r_berr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_funct3   <= funct3;
                        r_lane     <= addr[1:0];
                        r_is_store <= is_store;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        if (f3_illegal(funct3, is_store)) begin
                            r_state <= ST_RESP;
                            r_done  <= 1'b1;
                            r_berr  <= 1'b1;
                            r_rdata <= '0;
                        end else if (w_mis) begin
                            r_state <= ST_RESP;
                            r_done  <= 1'b1;
                            r_mis   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                            r_we    <= is_store;
                            r_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_state <= ST_RESP;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_rdata <= r_is_store ? '0 : w_rdata;
                    end else if (TIMEOUT_CYCLES != 0 && r_cnt == CNT_LAST) begin
                        r_state <= ST_RESP;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_berr  <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign rdata      = r_rdata;
    assign misaligned = r_mis;
    assign bus_error  = r_berr;
    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_be     = r_be;
    assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a driver that also plays the memory pushes
// expected bus beats and done responses; independent monitors pop and compare.
module tb_lsu_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy, done, misaligned, bus_error, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
        int unsigned cyc;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    done_t done_q[$];
    bus_t  bus_q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit is_illegal(input logic [2:0] f3, input bit st);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3 >= 3'd4);
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int unsigned     sz  = size_bytes(f3);
        int unsigned     off = a % 4;
        longint unsigned v;
        v = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if (f3 < 3'd4 && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1)
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        int unsigned sz = size_bytes(f3);
        if (sz == 1) return 32'(wd[7:0])  * 32'h0101_0101;
        if (sz == 2) return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    // ---------------- stimulus / memory ----------------
    // d < 0 means memory never acknowledges.
    task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int d, input bit hold);
        done_t       e;
        bus_t        b;
        int unsigned t0, sz;
        bit          ill, mis;
        @(posedge clk); #1;
        t0  = cyc;
        sz  = size_bytes(f3);
        ill = is_illegal(f3, st);
        mis = !ill && (a % sz != 0);
        e.rdata = '0;
        e.mis   = mis;
        e.berr  = ill;
        if (ill || mis) begin
            e.cyc = t0 + 1;
        end else begin
            b.addr  = a & ~32'd3;
            b.we    = st;
            b.be    = 4'(((1 << sz) - 1) << (a % 4));
            b.wdata = store_lanes(f3, wd);
            bus_q.push_back(b);
            if (d < 0) begin
                e.berr = 1'b1;
                e.cyc  = t0 + 1 + TO;
            end else begin
                e.cyc = t0 + 2 + d;
                if (!st) e.rdata = load_value(f3, a, rd);
            end
        end
        done_q.push_back(e);
        mem_ack  = 1'b0;
        start    = 1'b1;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        do begin
            @(posedge clk); #1;
            if (!hold || cyc == e.cyc) start = 1'b0;
            if (!start) begin
                addr     = $urandom;
                wdata    = $urandom;
                funct3   = 3'($urandom);
                is_store = 1'($urandom);
            end
            if (d >= 0 && !ill && !mis && cyc == t0 + 1 + d) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end while (cyc < e.cyc);
        mem_ack = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk); #1;
            start     = 1'b0;
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
        end
        mem_ack = 1'b0;
    endtask

    task automatic reset_mid();
        bus_t b;
        @(posedge clk); #1;
        b.addr  = 32'h2000_0010;
        b.we    = 1'b0;
        b.be    = 4'hF;
        b.wdata = '0;
        bus_q.push_back(b);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h2000_0010;
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid", 96'({mem_req, busy, done}), 96'(3'b000));
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- monitors ----------------
    initial begin : done_mon
        done_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected at cycle %0d: got done=1, expected none", cyc);
                end else begin
                    e = done_q.pop_front();
                    check("done", 96'({rdata, misaligned, bus_error, cyc}),
                          96'({e.rdata, e.mis, e.berr, e.cyc}));
                end
            end else if (misaligned || bus_error) begin
                n_checks++;
                $display("FAIL flag_without_done at cycle %0d: got mis=%0b berr=%0b, expected 0",
                         cyc, misaligned, bus_error);
            end
        end
    end

    initial begin : bus_mon
        bus_t cur;
        logic prev_req;
        prev_req = 1'b0;
        cur      = '{default: '0};
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL bus_unexpected at cycle %0d: got mem_req=1, expected 0", cyc);
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            if (mem_req)
                check("bus", 96'({mem_addr, mem_we, mem_be, mem_we ? mem_wdata : 32'h0, busy}),
                      96'({cur.addr, cur.we, cur.be, cur.we ? cur.wdata : 32'h0, 1'b1}));
            prev_req = mem_req;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected end of stimulus");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        bit          st, hold;
        logic [2:0]  f3;
        int          d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              96'({busy, done, rdata, misaligned, bus_error, mem_req, mem_we, mem_addr, mem_be}),
              96'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        do_txn(1'b0, 3'b010, 32'h1000_0008, 32'h0,         32'hDEAD_BEEF, 0,  1'b0);
        do_txn(1'b0, 3'b000, 32'h1000_0003, 32'h0,         32'h8011_2233, 1,  1'b0);
        do_txn(1'b0, 3'b100, 32'h1000_0003, 32'h0,         32'h8011_2233, 0,  1'b0);
        do_txn(1'b1, 3'b001, 32'h1000_0002, 32'h0000_ABCD, 32'h0,         2,  1'b0);
        do_txn(1'b0, 3'b010, 32'h1000_0006, 32'h0,         32'h1234_5678, 0,  1'b0);
        do_txn(1'b1, 3'b100, 32'h1000_0000, 32'h55,        32'h0,         0,  1'b0);
        do_txn(1'b0, 3'b010, 32'h1000_0004, 32'h0,         32'hFFFF_FFFF, -1, 1'b0);
        do_txn(1'b0, 3'b101, 32'h1000_0002, 32'h0,         32'h9ABC_DEF0, 3,  1'b1);
        do_txn(1'b0, 3'b001, 32'h1000_0002, 32'h0,         32'h8001_7FFF, 0,  1'b1);
        reset_mid();

        for (int i = 0; i < 120; i++) begin
            st   = 1'($urandom);
            f3   = 3'($urandom);
            d    = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(3));
            hold = ($urandom_range(3) == 0);
            do_txn(st, f3, $urandom, $urandom, $urandom, d, hold);
            idle($urandom_range(2));
        end

        idle(3);
        @(negedge clk);
        check("queues_drained", 96'({done_q.size(), bus_q.size()}), 96'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
